mc_issue_scoreboard: RTL and testbench

Parametrised issue-side hazard and dispatch controller for the multicycle and pipelined functional units in the EXE stage. It tracks per-unit occupancy, per-register pending writes (RAW/WAW), and single-writeback-port slot reservations, and produces a single issue stall plus a one-shot fire/duplicate-clear handshake so that an instruction held in ID/EXE is dispatched exactly once. It sits beside the pipeline controller, replaces the fixed 9-bit unit decode with an N-unit generic scheme, and feeds its stall into `id_exe_reg_en`/`pre_exe_stall`.

---
 rtl/mc_issue_scoreboard.sv | 125 ++++++++++++
 tb/tb_mc_issue_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_issue_scoreboard.sv
// Issue-side hazard/dispatch controller: unit occupancy, pending-write bitmap, one-shot fire.
// Optional writeback-slot reservation vector enabled by defining SB_WB_SLOT_EN.
module mc_issue_scoreboard #(
  parameter int                   NUM_UNITS  = 8,
  parameter logic [NUM_UNITS-1:0] ITER_MASK  = 8'h07,
  parameter int                   REG_ADDR_W = 6,
  parameter int                   MAX_LAT    = 32,
  localparam int                  LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_running,
  input  logic                  hold_in,
  input  logic                  flush,
  input  logic                  issue_new,
  input  logic                  issue_valid,
  input  logic [NUM_UNITS-1:0]  issue_unit,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_rd_we,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rs3,
  input  logic [2:0]            issue_rs_use,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  issue_fire,
  output logic                  issue_stall,
  output logic                  dup_clr,
  output logic [NUM_UNITS-1:0]  unit_busy,
  output logic                  raw_hazard,
  output logic                  waw_hazard,
  output logic                  wb_conflict
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [NREG-1:0]      pend_q, pend_d;
  logic [LAT_W-1:0]     cnt_q [NUM_UNITS];
  logic [LAT_W-1:0]     cnt_d [NUM_UNITS];
  logic                 fired_q, fired_d;
  logic [NUM_UNITS-1:0] unit_sel;
  logic                 lat_ok;
  logic                 stall_cause;

  // Malformed unit selects are treated as "no unit" so they never wait on occupancy.
  always_comb begin
    unit_sel = '0;
    if (issue_valid && (issue_unit != '0) &&
        ((issue_unit & (issue_unit - 1'b1)) == '0))
      unit_sel = issue_unit;
    lat_ok = (issue_lat != '0) && (issue_lat <= LAT_W'(MAX_LAT));
    for (int u = 0; u < NUM_UNITS; u++)
      unit_busy[u] = ITER_MASK[u] && (cnt_q[u] != '0);
    raw_hazard = (issue_rs_use[0] && pend_q[issue_rs1]) ||
                 (issue_rs_use[1] && pend_q[issue_rs2]) ||
                 (issue_rs_use[2] && pend_q[issue_rs3]);
    waw_hazard = issue_rd_we && pend_q[issue_rd];
  end

`ifdef SB_WB_SLOT_EN
  logic [MAX_LAT-1:0] slot_q, slot_d, slot_book;

  always_comb begin
    wb_conflict = 1'b0;
    slot_book   = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (lat_ok && (issue_lat == LAT_W'(i + 1))) begin
        wb_conflict  = slot_q[i];
        slot_book[i] = issue_fire;
      end
    end
    slot_d = (slot_q | slot_book) >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end
`else
  always_comb wb_conflict = 1'b0;
`endif

  // Fire and stall are held low while reset is asserted, even if ID/EXE looks valid.
  always_comb begin
    stall_cause = raw_hazard || waw_hazard || wb_conflict || ((unit_sel & unit_busy) != '0);
    issue_fire  = !rst && core_running && issue_valid && !fired_q && !hold_in &&
                  !flush && !stall_cause;
    issue_stall = !rst && issue_valid && !fired_q && stall_cause;
    dup_clr     = fired_q && issue_valid && !issue_new;
  end

  always_comb begin
    fired_d = fired_q;
    if (issue_new)  fired_d = 1'b0;
    if (issue_fire) fired_d = 1'b1;
    if (flush)      fired_d = 1'b0;

    pend_d = pend_q;
    if (wb_valid) pend_d[wb_rd] = 1'b0;
    if (issue_fire && issue_rd_we && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;

    for (int u = 0; u < NUM_UNITS; u++) begin
      cnt_d[u] = cnt_q[u];
      if (ITER_MASK[u] && issue_fire && unit_sel[u])
        cnt_d[u] = lat_ok ? (issue_lat - 1'b1) : '0;
      else if (cnt_q[u] != '0)
        cnt_d[u] = cnt_q[u] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      fired_q <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) cnt_q[u] <= '0;
    end else begin
      pend_q  <= pend_d;
      fired_q <= fired_d;
      for (int u = 0; u < NUM_UNITS; u++) cnt_q[u] <= cnt_d[u];
    end
  end

endmodule

// File: tb/tb_mc_issue_scoreboard.sv
// Directed bench for mc_issue_scoreboard: dispatch, occupancy, RAW/WAW, dup clear, reset.
module tb_mc_issue_scoreboard;
  localparam int NU = 8;
  localparam int RW = 6;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_running, hold_in, flush, issue_new, issue_valid;
  logic [NU-1:0] issue_unit;
  logic [LW-1:0] issue_lat;
  logic [RW-1:0] issue_rd, issue_rs1, issue_rs2, issue_rs3, wb_rd;
  logic          issue_rd_we, wb_valid;
  logic [2:0]    issue_rs_use;
  logic          issue_fire, issue_stall, dup_clr, raw_hazard, waw_hazard, wb_conflict;
  logic [NU-1:0] unit_busy;

  int n_cmp = 0;
  int n_err = 0;

  mc_issue_scoreboard dut (
    .clk(clk), .rst(rst), .core_running(core_running), .hold_in(hold_in),
    .flush(flush), .issue_new(issue_new), .issue_valid(issue_valid),
    .issue_unit(issue_unit), .issue_lat(issue_lat), .issue_rd(issue_rd),
    .issue_rd_we(issue_rd_we), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs3(issue_rs3), .issue_rs_use(issue_rs_use), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .issue_fire(issue_fire), .issue_stall(issue_stall),
    .dup_clr(dup_clr), .unit_busy(unit_busy), .raw_hazard(raw_hazard),
    .waw_hazard(waw_hazard), .wb_conflict(wb_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [NU-1:0] u, input int lat, input int rd, input bit we,
                        input int rs1, input logic [2:0] use_v);
    issue_unit   = u;
    issue_lat    = LW'(lat);
    issue_rd     = RW'(rd);
    issue_rd_we  = we;
    issue_rs1    = RW'(rs1);
    issue_rs2    = '0;
    issue_rs3    = '0;
    issue_rs_use = use_v;
  endtask

  initial begin
    rst = 1'b1; core_running = 1'b1; hold_in = 1'b0; flush = 1'b0;
    issue_new = 1'b1; issue_valid = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    set_op(8'h01, 4, 0, 1'b0, 0, 3'b000);
    #2;
    chk("rst_fire", issue_fire, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_dup", dup_clr, 0);
    chk("rst_busy", unit_busy, 0);
    chk("rst_raw", raw_hazard, 0);
    chk("rst_waw", waw_hazard, 0);
    chk("rst_wbc", wb_conflict, 0);

    @(negedge clk); rst = 1'b0; #1;
    chk("t0_fire", issue_fire, 1);
    tick(); issue_new = 1'b0; #1;
    chk("t1_busy", unit_busy, 8'h01);
    chk("t1_dup", dup_clr, 1);
    chk("t1_fire", issue_fire, 0);
    tick(); issue_new = 1'b1; set_op(8'h01, 2, 9, 1'b1, 0, 3'b000); #1;
    chk("t2_busy", unit_busy, 8'h01);
    chk("t2_fire", issue_fire, 0);
    chk("t2_dup", dup_clr, 0);
    tick(); issue_new = 1'b0; #1;
    chk("t3_stall", issue_stall, 1);
    chk("t3_fire", issue_fire, 0);
    tick(); #1;
    chk("t4_busy", unit_busy, 0);
    chk("t4_fire", issue_fire, 1);

    tick(); #1;
    chk("t5_dup", dup_clr, 1);
    chk("t5_fire", issue_fire, 0);
    chk("t5_waw", waw_hazard, 1);
    chk("t5_busy", unit_busy, 8'h01);
    tick(); #1;
    chk("t6_dup", dup_clr, 1);
    chk("t6_busy", unit_busy, 0);
    tick(); #1;
    chk("t7_dup", dup_clr, 1);
    tick(); wb_valid = 1'b1; wb_rd = 6'd9; #1;
    chk("t8_dup", dup_clr, 1);
    chk("t8_fire", issue_fire, 0);
    tick(); wb_valid = 1'b0; #1;
    chk("t9_waw", waw_hazard, 0);
    chk("t9_fire", issue_fire, 0);

    tick(); issue_new = 1'b1; set_op(8'h08, 3, 5, 1'b1, 0, 3'b000); #1;
    chk("A_fire", issue_fire, 0);
    tick(); issue_new = 1'b0; #1;
    chk("B_fire", issue_fire, 1);
    tick(); issue_new = 1'b1; set_op(8'h08, 1, 0, 1'b0, 5, 3'b001); #1;
    chk("C_raw", raw_hazard, 1);
    chk("C_stall", issue_stall, 0);
    tick(); issue_new = 1'b0; #1;
    chk("D_raw", raw_hazard, 1);
    chk("D_stall", issue_stall, 1);
    tick(); wb_valid = 1'b1; wb_rd = 6'd5; #1;
    chk("E_raw", raw_hazard, 1);
    chk("E_fire", issue_fire, 0);
    tick(); wb_valid = 1'b0; #1;
    chk("F_raw", raw_hazard, 0);
    chk("F_fire", issue_fire, 1);

    tick(); issue_new = 1'b1; set_op(8'h08, 2, 7, 1'b1, 0, 3'b000); #1;
    chk("G_fire", issue_fire, 0);
    tick(); issue_new = 1'b0; wb_valid = 1'b1; wb_rd = 6'd7; #1;
    chk("H_fire", issue_fire, 1);
    tick(); wb_valid = 1'b0; issue_new = 1'b1; #1;
    chk("I_waw", waw_hazard, 1);
    tick(); issue_new = 1'b0; wb_valid = 1'b1; wb_rd = 6'd7; #1;
    chk("J_waw", waw_hazard, 1);
    chk("J_stall", issue_stall, 1);
    chk("J_fire", issue_fire, 0);
    tick(); wb_valid = 1'b0; #1;
    chk("K_waw", waw_hazard, 0);
    chk("K_fire", issue_fire, 1);

    tick(); issue_new = 1'b1; set_op(8'h08, 1, 0, 1'b0, 0, 3'b000); #1;
    tick(); issue_new = 1'b0; hold_in = 1'b1; #1;
    chk("M_hold_fire", issue_fire, 0);
    chk("M_hold_stall", issue_stall, 0);
    tick(); hold_in = 1'b0; core_running = 1'b0; #1;
    chk("N_frozen_fire", issue_fire, 0);
    tick(); core_running = 1'b1; flush = 1'b1; #1;
    chk("O_flush_fire", issue_fire, 0);
    chk("O_flush_dup", dup_clr, 0);
    tick(); flush = 1'b0; #1;
    chk("P_fire", issue_fire, 1);

    tick(); issue_new = 1'b1; set_op(8'h01, 5, 0, 1'b0, 0, 3'b000); #1;
    tick(); issue_new = 1'b0; #1;
    chk("R_fire", issue_fire, 1);
    tick(); issue_new = 1'b1; set_op(8'h03, 1, 0, 1'b0, 0, 3'b000); #1;
    chk("S_busy", unit_busy, 8'h01);
    tick(); issue_new = 1'b0; #1;
    chk("T_nonoh_fire", issue_fire, 1);
    chk("T_busy", unit_busy, 8'h01);
    tick(); issue_new = 1'b1; set_op(8'h01, 1, 0, 1'b0, 0, 3'b000); #1;
    tick(); issue_new = 1'b0; #1;
    chk("V_stall", issue_stall, 1);
    chk("V_fire", issue_fire, 0);
    tick(); #1;
    chk("W_fire", issue_fire, 1);
    tick(); issue_new = 1'b1; #1;
    chk("X_lat1_busy", unit_busy, 0);
    chk("X_fire", issue_fire, 0);

    tick(); set_op(8'h08, 4, 0, 1'b0, 0, 3'b000); #1;
    chk("Y_fire", issue_fire, 1);
    tick(); set_op(8'h08, 3, 0, 1'b0, 0, 3'b000); #1;
`ifdef SB_WB_SLOT_EN
    chk("Z_wbc_l3", wb_conflict, 1);
`else
    chk("Z_wbc_l3", wb_conflict, 0);
`endif
    issue_lat = 6'd2; #1;
    chk("Z_wbc_l2", wb_conflict, 0);
    tick(); issue_new = 1'b0; #1;
`ifdef SB_WB_SLOT_EN
    chk("Z1_wbc", wb_conflict, 1);
    chk("Z1_stall", issue_stall, 1);
    chk("Z1_fire", issue_fire, 0);
    tick(); #1;
    chk("Z2_fire", issue_fire, 1);
`else
    chk("Z1_wbc", wb_conflict, 0);
    chk("Z1_fire", issue_fire, 1);
    tick(); #1;
    chk("Z2_fire", issue_fire, 0);
    chk("Z2_dup", dup_clr, 1);
`endif

    tick(); issue_new = 1'b1; set_op(8'h02, 10, 12, 1'b1, 0, 3'b000); #1;
    chk("R0_fire", issue_fire, 0);
    tick(); issue_new = 1'b0; #1;
    chk("R1_fire", issue_fire, 1);
    tick(); #1;
    chk("R2_busy", unit_busy, 8'h02);
    chk("R2_waw", waw_hazard, 1);
    chk("R2_dup", dup_clr, 1);
    tick(); tick(); #1;
    chk("R4_busy", unit_busy, 8'h02);
    rst = 1'b1; #1;
    chk("arst_busy", unit_busy, 0);
    chk("arst_waw", waw_hazard, 0);
    chk("arst_dup", dup_clr, 0);
    chk("arst_fire", issue_fire, 0);
    tick(); rst = 1'b0; issue_valid = 1'b0; #1;
    chk("post_busy", unit_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
